mem_stage_lsu: RTL

//  MEM-stage load/store unit between the EX/MEM pipeline register and flip_flop_WB.

---
 rtl/mem_stage_lsu_if.sv | 22 ++
 rtl/mem_stage_lsu.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port of the MEM-stage load/store unit.
//   req    master->slave  access request (held until ready or abort)
//   we     master->slave  1 = write
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  store data, lane-replicated
//   be     master->slave  byte enables
//   ready  slave->master  access completes in a cycle with req && ready
//   rdata  slave->master  read word, valid with ready
interface mem_stage_lsu_if #(
    parameter int DATA_LENGTH = 32
);
    logic                     req;
    logic                     we;
    logic [DATA_LENGTH-1:0]   addr;
    logic [DATA_LENGTH-1:0]   wdata;
    logic [DATA_LENGTH/8-1:0] be;
    logic                     ready;
    logic [DATA_LENGTH-1:0]   rdata;

    modport master (output req, we, addr, wdata, be, input  ready, rdata);
    modport slave  (input  req, we, addr, wdata, be, output ready, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit. Issues loads/stores on the data-memory port,
// aligns and extends load data, picks the write-back value and stalls the
// pipeline while an access is outstanding.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_inst/i_alu_out/i_rs2_data/i_pc/i_rd/i_regWEn/i_wbsel  EX/MEM register
//   dmem                data-memory port (master side)
//   o_inst, o_rd        pass-through to the WB register
//   o_wbout, o_regWEn   write-back value and gated write enable
//   o_stall             freeze PC and IF/ID/EX/MEM registers
//   o_misalign          misaligned access (combinational)
//   o_bus_err           one-cycle pulse when an access times out
module mem_stage_lsu #(
    parameter int DATA_LENGTH     = 32,
    parameter int REG_ADDR_LENGTH = 5,
    parameter int INST_LENGTH     = 32,
    parameter int TIMEOUT         = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [INST_LENGTH-1:0]     i_inst,
    input  logic [DATA_LENGTH-1:0]     i_alu_out,
    input  logic [DATA_LENGTH-1:0]     i_rs2_data,
    input  logic [DATA_LENGTH-1:0]     i_pc,
    input  logic [REG_ADDR_LENGTH-1:0] i_rd,
    input  logic                       i_regWEn,
    input  logic [1:0]                 i_wbsel,
    mem_stage_lsu_if.master            dmem,
    output logic [INST_LENGTH-1:0]     o_inst,
    output logic [REG_ADDR_LENGTH-1:0] o_rd,
    output logic [DATA_LENGTH-1:0]     o_wbout,
    output logic                       o_regWEn,
    output logic                       o_stall,
    output logic                       o_misalign,
    output logic                       o_bus_err
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    // Abort on the TIMEOUT-th REQ cycle; cnt holds REQ cycles already elapsed.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                 state;
    logic                   req_q, we_q, err_q;
    logic [3:0]             cnt;
    logic [DATA_LENGTH-1:0] rdata_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [1:0] a_lo;
    logic       is_load, is_store, mem_op, misaligned;

    assign opcode   = i_inst[6:0];
    assign funct3   = i_inst[14:12];
    assign a_lo     = i_alu_out[1:0];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign mem_op   = is_load | is_store;
    // funct3[1:0]: 00 byte, 01 half, 10 word (shared by loads and stores)
    assign misaligned = mem_op &&
                        (((funct3[1:0] == 2'b01) && a_lo[0]) ||
                         ((funct3[1:0] == 2'b10) && (a_lo != 2'b00)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt     <= '0;
            rdata_q <= '0;
            o_bus_err <= 1'b0;
        end else begin
            o_bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    err_q <= 1'b0;
                    if (mem_op && !misaligned) begin
                        state <= REQ;
                        req_q <= 1'b1;
                        we_q  <= is_store;
                    end
                end
                REQ: begin
                    if (dmem.ready) begin
                        rdata_q <= dmem.rdata;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state   <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        req_q     <= 1'b0;
                        we_q      <= 1'b0;
                        err_q     <= 1'b1;
                        o_bus_err <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst_n so a reset mid-access releases the pipeline at once.
    assign o_stall = rst_n && ((state == REQ) ||
                               ((state == IDLE) && mem_op && !misaligned));

    assign dmem.req  = req_q;
    assign dmem.we   = we_q;
    assign dmem.addr = {i_alu_out[DATA_LENGTH-1:2], 2'b00};

    always_comb begin
        dmem.be    = '0;
        dmem.wdata = i_rs2_data;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    dmem.be    = 4'b0001 << a_lo;
                    dmem.wdata = {4{i_rs2_data[7:0]}};
                end
                2'b01: begin
                    dmem.be    = a_lo[1] ? 4'b1100 : 4'b0011;
                    dmem.wdata = {2{i_rs2_data[15:0]}};
                end
                default: dmem.be = 4'b1111;
            endcase
        end
    end

    // Load lane extraction: bring the addressed byte/half down to bit 0.
    logic [DATA_LENGTH-1:0] shifted, load_data;
    assign shifted = rdata_q >> {a_lo, 3'b000};

    always_comb begin
        load_data = shifted;
        case (funct3)
            3'b000:  load_data = {{(DATA_LENGTH-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_data = {{(DATA_LENGTH-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {{(DATA_LENGTH-8){1'b0}},         shifted[7:0]};
            3'b101:  load_data = {{(DATA_LENGTH-16){1'b0}},        shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        case (i_wbsel)
            2'b00:   o_wbout = load_data;
            2'b10:   o_wbout = i_pc + DATA_LENGTH'(4);
            default: o_wbout = i_alu_out;
        endcase
    end

    assign o_regWEn   = i_regWEn && !misaligned && !((state == RESP) && err_q);
    assign o_misalign = misaligned;
    assign o_inst     = i_inst;
    assign o_rd       = i_rd;
endmodule
